// File: rtl/fdiv_if.sv
// fdiv_if: p_float type and valid/ready operand/result bundle for the iterative divider
package fdiv_pkg;
  localparam int EXP = 8;
  localparam int FRAC = 12;
  typedef struct packed {
    logic            sign;
    logic [EXP:0]    exp;
    logic [FRAC:0]   frac;
  } p_float;
endpackage

interface fdiv_if;
  import fdiv_pkg::*;
  logic   in_valid;
  logic   in_ready;
  p_float a;
  p_float b;
  logic   out_valid;
  logic   out_ready;
  p_float c;
  modport master (output in_valid, output a, output b, output out_ready, input in_ready, input out_valid, input c);
  modport slave (input in_valid, input a, input b, input out_ready, output in_ready, output out_valid, output c);
endinterface

// File: rtl/fdiv.sv
// fdiv: iterative restoring p_float divider with round-to-nearest-even, one operation at a time
module fdiv (
  input logic   clk,
  input logic   rst,
  fdiv_if.slave io
);
  import fdiv_pkg::*;
  typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;
  state_t        state_q, state_d;
  logic          sign_q, sign_d;
  logic [EXP:0]  e_q, e_d;
  logic [FRAC:0] af_q, af_d, bf_q, bf_d;
  logic [FRAC+2:0] rem_q, rem_d, q_q, q_d;
  logic [3:0]    cnt_q, cnt_d;
  p_float        c_q, c_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          bit_v, round_up;
  logic [FRAC+2:0] diff;
  logic [FRAC:0] mant;
  logic [FRAC+1:0] mant_r;
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    e_d = e_q;
    af_d = af_q;
    bf_d = bf_q;
    rem_d = rem_q;
    q_d = q_q;
    cnt_d = cnt_q;
    c_d = c_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    bit_v = rem_q >= {2'b0, bf_q};
    diff = bit_v ? rem_q - {2'b0, bf_q} : rem_q;
    mant = q_q[FRAC+2:2];
    // remainder nonzero after the last step acts as the sticky bit
    round_up = q_q[1] & (q_q[0] | (rem_q != '0) | mant[0]);
    mant_r = {1'b0, mant} + {{(FRAC+1){1'b0}}, round_up};
    case (state_q)
      IDLE: if (io.in_valid) begin
        sign_d = io.a.sign ^ io.b.sign;
        e_d = io.a.exp - io.b.exp;
        af_d = io.a.frac;
        bf_d = io.b.frac;
        in_ready_d = 1'b0;
        state_d = PREP;
      end
      PREP: begin
        rem_d = (af_q < bf_q) ? {1'b0, af_q, 1'b0} : {2'b0, af_q};
        e_d = (af_q < bf_q) ? e_q - 9'd1 : e_q;
        q_d = '0;
        cnt_d = '0;
        state_d = ITER;
      end
      ITER: begin
        rem_d = diff << 1;
        q_d = {q_q[FRAC+1:0], bit_v};
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(FRAC + 2)) ? ROUND : ITER;
      end
      ROUND: begin
        c_d.sign = sign_q;
        c_d.exp = mant_r[FRAC+1] ? e_q + 9'd1 : e_q;
        c_d.frac = mant_r[FRAC+1] ? mant_r[FRAC+1:1] : mant_r[FRAC:0];
        out_valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (io.out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        in_ready_d = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      e_q <= '0;
      af_q <= '0;
      bf_q <= '0;
      rem_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      c_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      e_q <= e_d;
      af_q <= af_d;
      bf_q <= bf_d;
      rem_q <= rem_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      c_q <= c_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign io.in_ready = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.c = c_q;
endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: scoreboard bench for fdiv against an exact-rational RNE reference model
module tb_fdiv;
  import fdiv_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  p_float exp_q[$];
  fdiv_if bus();
  fdiv dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic p_float mk(input logic s, input logic [8:0] e, input logic [12:0] f);
    p_float r;
    r.sign = s;
    r.exp = e;
    r.frac = f;
    return r;
  endfunction

  // exact quotient scaled to a 13-bit mantissa, then nearest-even on the remainder
  function automatic p_float model(input p_float x, input p_float y);
    p_float r;
    logic [8:0] e;
    longint num, qt, rm;
    int sh;
    e = x.exp - y.exp;
    sh = 12;
    if (x.frac < y.frac) begin
      e = e - 9'd1;
      sh = 13;
    end
    num = longint'(x.frac) << sh;
    qt = num / longint'(y.frac);
    rm = num % longint'(y.frac);
    if (2 * rm > longint'(y.frac) || (2 * rm == longint'(y.frac) && qt[0])) qt++;
    if (qt == 8192) begin
      qt = 4096;
      e = e + 9'd1;
    end
    r.sign = x.sign ^ y.sign;
    r.exp = e;
    r.frac = qt[12:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h expected none", bus.c);
      end else begin
        chk("result", 32'(bus.c), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input p_float x, input p_float y, input p_float ex);
    int n = 0;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else exp_q.push_back(ex);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = 23'($urandom);
    bus.b = 23'($urandom);
  endtask

  task automatic lat();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
    chk("latency", 32'(n), 32'd18);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    p_float one, three, two, m6, p_c, x, y;
    int n;
    one = mk(0, 9'h000, 13'h1000);
    three = mk(0, 9'h001, 13'h1800);
    two = mk(0, 9'h001, 13'h1000);
    m6 = mk(1, 9'h002, 13'h1800);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_c", 32'(bus.c), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(one, one, one);
    lat();
    drain();
    send(three, two, mk(0, 9'h000, 13'h1800));
    drain();
    send(m6, two, mk(1, 9'h001, 13'h1800));
    drain();
    send(mk(0, 9'h000, 13'h1000), three, mk(0, 9'h1FE, 13'h1555));
    drain();
    send(one, mk(0, 9'h000, 13'h1001), mk(0, 9'h1FF, 13'h1FFE));
    drain();
    bus.out_ready = 1'b0;
    send(three, two, mk(0, 9'h000, 13'h1800));
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
    p_c = bus.c;
    chk("bp_first_c", 32'(p_c), 32'(mk(0, 9'h000, 13'h1800)));
    bus.a = m6;
    bus.b = one;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_c_stable", 32'(bus.c), 32'(p_c));
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    send(three, two, mk(0, 9'h000, 13'h1800));
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(three, two, mk(0, 9'h000, 13'h1800));
    lat();
    drain();
    for (int i = 0; i < 2000; i++) begin
      x = mk(1'($urandom), 9'($urandom), {1'b1, 12'($urandom)});
      y = mk(1'($urandom), 9'($urandom), {1'b1, 12'($urandom)});
      if (i % 4 == 0) y.frac = {1'b1, x.frac[11:0]};
      send(x, y, model(x, y));
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
